sw_digit_buffer: RTL and testbench

Sequential digit-entry stage directly downstream of the switch-toggle decoder. It consumes the decoder's `hex` and `pulse` pair, where `pulse` is a one-cycle strobe qualifying `hex`. Accepted digits are assembled into a multi-digit BCD/hex buffer, with backspace, clear and enter (commit) controls. The live buffer drives the 7-segment display path, and committed values go to the downstream compute/compare logic.

---
 rtl/sw_digit_buffer.sv | 149 ++++++++++++++
 tb/tb_sw_digit_buffer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sw_digit_buffer.sv
// Digit-entry buffer: shifts accepted decoder digits into a multi-digit
// register with backspace, clear and commit, and holds the last committed value.
module sw_digit_buffer #(
  parameter int DIGITS    = 4,
  parameter int MAX_DIGIT = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    hex,
  input  logic                          pulse,
  input  logic                          del,
  input  logic                          clr,
  input  logic                          enter,
  output logic [4*DIGITS-1:0]           buf_out,
  output logic [$clog2(DIGITS+1)-1:0]   count,
  output logic                          full,
  output logic [4*DIGITS-1:0]           data_out,
  output logic                          valid
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [CW-1:0] DIGITS_C = CW'(DIGITS);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [3:0]    MAX_HEX  = 4'(MAX_DIGIT);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_EDIT,
    ST_FULL
  } state_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_CLR,
    ACT_ENTER,
    ACT_DEL,
    ACT_DIGIT
  } act_t;

  state_t          state_reg, state_next;
  act_t            act;
  logic [BW-1:0]   buf_reg, buf_next;
  logic [BW-1:0]   data_reg, data_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            valid_reg, valid_next;
  logic [BW-1:0]   shift_in;
  logic [BW-1:0]   shift_out;

  // Per-slot shift network; slot 0 holds the newest digit.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_slot
      if (gi == 0) begin : g_first
        assign shift_in[3:0] = hex;
      end else begin : g_rest
        assign shift_in[4*gi +: 4] = buf_reg[4*(gi-1) +: 4];
      end
      if (gi == DIGITS - 1) begin : g_last
        assign shift_out[4*gi +: 4] = 4'h0;
      end else begin : g_inner
        assign shift_out[4*gi +: 4] = buf_reg[4*(gi+1) +: 4];
      end
    end
  endgenerate

  // One action per cycle; lower-priority requests are dropped, not queued.
  always_comb begin
    act = ACT_NONE;
    if (clr) begin
      act = ACT_CLR;
    end else if (enter) begin
      act = ACT_ENTER;
    end else if (del) begin
      act = ACT_DEL;
    end else if (pulse && (hex <= MAX_HEX)) begin
      act = ACT_DIGIT;
    end
  end

  always_comb begin
    buf_next   = buf_reg;
    count_next = count_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    state_next = state_reg;

    case (act)
      ACT_CLR: begin
        buf_next   = '0;
        count_next = '0;
      end
      ACT_ENTER: begin
        if (state_reg != ST_EMPTY) begin
          data_next  = buf_reg;
          valid_next = 1'b1;
          buf_next   = '0;
          count_next = '0;
        end
      end
      ACT_DEL: begin
        if (state_reg != ST_EMPTY) begin
          buf_next   = shift_out;
          count_next = count_reg - ONE_C;
        end
      end
      ACT_DIGIT: begin
        if (state_reg != ST_FULL) begin
          buf_next   = shift_in;
          count_next = count_reg + ONE_C;
        end
      end
      default: begin
      end
    endcase

    // State tracks the digit count it will hold after this edge.
    if (count_next == '0) begin
      state_next = ST_EMPTY;
    end else if (count_next == DIGITS_C) begin
      state_next = ST_FULL;
    end else begin
      state_next = ST_EDIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
      buf_reg   <= '0;
      count_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      buf_reg   <= buf_next;
      count_reg <= count_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
    end
  end

  assign buf_out  = buf_reg;
  assign count    = count_reg;
  assign full     = (count_reg == DIGITS_C);
  assign data_out = data_reg;
  assign valid    = valid_reg;

endmodule

// File: tb/tb_sw_digit_buffer.sv
// Bench for sw_digit_buffer: directed scenarios followed by random traffic,
// all compared against a queue-based model of the digit buffer.
module tb_sw_digit_buffer;

  localparam int DIGITS    = 4;
  localparam int MAX_DIGIT = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  hex;
  logic        pulse, del, clr, enter;
  logic [15:0] buf_out;
  logic [2:0]  count;
  logic        full;
  logic [15:0] data_out;
  logic        valid;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: digits oldest-first, newest at the back.
  int          m_q[$];
  logic [15:0] m_data;
  logic        m_valid;

  sw_digit_buffer #(.DIGITS(DIGITS), .MAX_DIGIT(MAX_DIGIT)) dut (
    .clk(clk), .rst(rst), .hex(hex), .pulse(pulse), .del(del),
    .clr(clr), .enter(enter), .buf_out(buf_out), .count(count),
    .full(full), .data_out(data_out), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pack_model();
    logic [15:0] v = '0;
    for (int i = 0; i < m_q.size(); i++) begin
      v = v | (16'(m_q[m_q.size()-1-i]) << (4*i));
    end
    return v;
  endfunction

  function automatic void model_step(input logic r, input logic [3:0] h, input logic p,
                                     input logic d, input logic c, input logic e);
    m_valid = 1'b0;
    if (r) begin
      m_q.delete();
      m_data = '0;
    end else if (c) begin
      m_q.delete();
    end else if (e) begin
      if (m_q.size() > 0) begin
        m_data  = pack_model();
        m_valid = 1'b1;
        m_q.delete();
      end
    end else if (d) begin
      if (m_q.size() > 0) void'(m_q.pop_back());
    end else if (p && h <= MAX_DIGIT && m_q.size() < DIGITS) begin
      m_q.push_back(int'(h));
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".buf"},   32'(buf_out),  32'(pack_model()));
    check({tag, ".count"}, 32'(count),    32'(m_q.size()));
    check({tag, ".full"},  32'(full),     32'(m_q.size() == DIGITS));
    check({tag, ".data"},  32'(data_out), 32'(m_data));
    check({tag, ".valid"}, 32'(valid),    32'(m_valid));
  endtask

  task automatic step(input string tag, input logic r, input logic [3:0] h, input logic p,
                      input logic d, input logic c, input logic e);
    @(negedge clk);
    rst = r; hex = h; pulse = p; del = d; clr = c; enter = e;
    @(posedge clk);
    model_step(r, h, p, d, c, e);
    #1;
    $display("%s: rst=%0b hex=%0d pulse=%0b del=%0b clr=%0b enter=%0b -> buf=%h cnt=%0d full=%0b data=%h valid=%0b",
             tag, r, h, p, d, c, e, buf_out, count, full, data_out, valid);
    check_all(tag);
  endtask

  initial begin
    m_data = '0; m_valid = 1'b0;
    rst = 1'b1; hex = 4'd10; pulse = 0; del = 0; clr = 0; enter = 0;

    step("reset", 1, 4'd10, 0, 0, 0, 0);
    check("reset.const_buf", 32'(buf_out), 32'h0);

    // Scenario 1/2: fill and overflow attempt
    step("d1", 0, 4'd1, 1, 0, 0, 0);
    step("d2", 0, 4'd2, 1, 0, 0, 0);
    step("d3", 0, 4'd3, 1, 0, 0, 0);
    check("t1.buf", 32'(buf_out), 32'h0123);
    step("d4", 0, 4'd4, 1, 0, 0, 0);
    check("t2.buf", 32'(buf_out), 32'h1234);
    check("t2.full", 32'(full), 32'd1);
    step("d5_full", 0, 4'd5, 1, 0, 0, 0);
    check("t2.hold", 32'(buf_out), 32'h1234);
    check("t2.count", 32'(count), 32'd4);

    // Scenario 3: backspace then commit
    step("del", 0, 4'd10, 0, 1, 0, 0);
    check("t3.del", 32'(buf_out), 32'h0123);
    step("enter", 0, 4'd10, 0, 0, 0, 1);
    check("t3.data", 32'(data_out), 32'h0123);
    check("t3.valid", 32'(valid), 32'd1);
    step("idle", 0, 4'd10, 0, 0, 0, 0);
    check("t3.valid_drop", 32'(valid), 32'd0);

    // Scenario 4: empty enter and idle code
    step("enter_empty", 0, 4'd10, 0, 0, 0, 1);
    check("t4.valid", 32'(valid), 32'd0);
    check("t4.data", 32'(data_out), 32'h0123);
    step("hex10", 0, 4'd10, 1, 0, 0, 0);
    check("t4.count", 32'(count), 32'd0);

    // Scenario 5: clr beats enter and digit
    step("d4b", 0, 4'd4, 1, 0, 0, 0);
    step("d2b", 0, 4'd2, 1, 0, 0, 0);
    step("clr_all", 0, 4'd7, 1, 0, 1, 1);
    check("t5.buf", 32'(buf_out), 32'h0);
    check("t5.data", 32'(data_out), 32'h0123);

    // Scenario 6: reset overrides a coincident enter
    step("d4c", 0, 4'd4, 1, 0, 0, 0);
    step("d2c", 0, 4'd2, 1, 0, 0, 0);
    step("rst_enter", 1, 4'd10, 0, 0, 0, 1);
    check("t6.valid", 32'(valid), 32'd0);
    check("t6.data", 32'(data_out), 32'h0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic r, p, d, c, e;
      logic [3:0] h;
      r = ($urandom_range(0, 99) == 0);
      p = ($urandom_range(0, 99) < 60);
      d = ($urandom_range(0, 99) < 12);
      c = ($urandom_range(0, 99) < 4);
      e = ($urandom_range(0, 99) < 8);
      h = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      step($sformatf("rnd%0d", i), r, h, p, d, c, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
